// File: rtl/window_avg_out_stage_pkg.sv
// ---------------------------------------------------------------------------
// window_avg_out_stage_pkg
//   Shared definitions for the windowed-average output stages.
//   - occ_t        : 2-bit buffer occupancy (0..2), shared with sibling stages
//   - fifo_op_e    : push/pop combination seen by a 2-entry buffer in a cycle
//   - warm_count() : number of posedges before the adder window is fully
//                    populated (2^N samples plus adder latency, minus one)
//   - round_const(): half-LSB term added before the >>N scaling, or 0
//   - cnt_width()  : bit width of a counter that must reach warm_count()
// ---------------------------------------------------------------------------
package window_avg_out_stage_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

  // Encoded as {push, pop} so a concatenation casts straight to the enum.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int warm_count(input int n, input int add_lat);
    return (1 << n) + add_lat - 1;
  endfunction

  // N=0 has no fractional bits, so there is nothing to round.
  function automatic int round_const(input int n, input int round_en);
    if ((round_en != 0) && (n > 0)) begin
      return 1 << (n - 1);
    end
    return 0;
  endfunction

  // +2 keeps the width at least 1 even when the terminal count is 0.
  function automatic int cnt_width(input int warm);
    return $clog2(warm + 2);
  endfunction

endpackage

// File: rtl/window_avg_out_stage_if.sv
// ---------------------------------------------------------------------------
// window_avg_out_stage_if
//   Valid/ready result channel of the windowed-average output stage.
//   Signals:
//     avg_out   [DW] result data (head of the output buffer, 0 when empty)
//     avg_valid [1]  avg_out holds a result
//     avg_ready [1]  sink accepts avg_out this cycle when avg_valid=1
//   Modports:
//     master : the stage producing results (drives avg_out/avg_valid)
//     slave  : the sink consuming results (drives avg_ready)
// ---------------------------------------------------------------------------
interface window_avg_out_stage_if
  import window_avg_out_stage_pkg::*;
#(
  parameter int DW = 8
);

  logic [DW-1:0] avg_out;
  logic          avg_valid;
  logic          avg_ready;

  modport master (
    output avg_out,
    output avg_valid,
    input  avg_ready
  );

  modport slave (
    input  avg_out,
    input  avg_valid,
    output avg_ready
  );

endinterface

// File: rtl/window_avg_out_stage_fifo.sv
// ---------------------------------------------------------------------------
// avg_skid_fifo
//   Two-entry FIFO holding scaled averages between production and the sink.
//   Show-ahead: dout presents the head entry combinationally from the slot
//   registers, and reads 0 while the FIFO is empty.
//   Ports:
//     clk    in   clock, all state on posedge
//     rst_n  in   synchronous active-low reset (empties the FIFO)
//     push   in   write din this cycle (ignored when full unless popping)
//     pop    in   remove the head entry this cycle (ignored when empty)
//     din    in   [DW] data to write
//     dout   out  [DW] head entry, 0 when empty
//     full   out  two entries held
//     empty  out  no entries held
// ---------------------------------------------------------------------------
module avg_skid_fifo
  import window_avg_out_stage_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  occ_t          count_reg;
  logic          pop_ok;
  logic          push_ok;
  fifo_op_e      op;
  logic [DW-1:0] slot_data [2];

  assign empty = (count_reg == OCC_EMPTY);
  assign full  = (count_reg == OCC_FULL);

  // A push into a full FIFO is accepted when the head leaves in the same
  // cycle: the write lands in the slot being vacated (wr_ptr == rd_ptr).
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign op      = fifo_op_e'({push_ok, pop_ok});

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic [DW-1:0] data_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= din;
        end
      end

      assign slot_data[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= OCC_EMPTY;
    end else begin
      case (op)
        OP_PUSH: begin
          wr_ptr_reg <= ~wr_ptr_reg;
          count_reg  <= count_reg + 2'd1;
        end
        OP_POP: begin
          rd_ptr_reg <= ~rd_ptr_reg;
          count_reg  <= count_reg - 2'd1;
        end
        OP_BOTH: begin
          wr_ptr_reg <= ~wr_ptr_reg;
          rd_ptr_reg <= ~rd_ptr_reg;
        end
        default: begin
        end
      endcase
    end
  end

  assign dout = empty ? '0 : slot_data[rd_ptr_reg];

endmodule

// File: rtl/window_avg_out_stage.sv
// ---------------------------------------------------------------------------
// window_avg_out_stage
//   Consumer of the 2^N past-sequence adder. Waits until the adder window is
//   fully populated, scales each window sum to a mean (sum >> N, optionally
//   rounded half up) and queues the results in a 2-entry buffer toward a
//   valid/ready sink. Results arriving while the buffer is full and not
//   draining are dropped and flagged with a sticky overflow.
//   Parameters:
//     DW       width of sum_in and avg_out
//     N        log2 of window length
//     ADD_LAT  adder latency from sample in to sum_in
//     ROUND    1: round half up, 0: truncate
//   Ports:
//     clk       in   clock, all state on posedge
//     rst_n     in   synchronous active-low reset
//     sum_in    in   [DW] window sum, new value every cycle
//     flush     in   restart warm-up; queued results still drain
//     warm      out  window populated, results being produced
//     overflow  out  sticky: a result was dropped on a full buffer
//     out_if    master side of the avg_out/avg_valid/avg_ready channel
// ---------------------------------------------------------------------------
module window_avg_out_stage
  import window_avg_out_stage_pkg::*;
#(
  parameter int DW      = 8,
  parameter int N       = 4,
  parameter int ADD_LAT = 1,
  parameter int ROUND   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DW-1:0]                 sum_in,
  input  logic                          flush,
  output logic                          warm,
  output logic                          overflow,
  window_avg_out_stage_if.master        out_if
);

  localparam int            WARM   = warm_count(N, ADD_LAT);
  localparam int            CW     = cnt_width(WARM);
  localparam logic [CW-1:0] WARM_C = CW'(WARM);
  localparam logic [DW:0]   RC     = (DW + 1)'(round_const(N, ROUND));

  logic [CW-1:0] warm_cnt_reg;
  logic [CW-1:0] warm_cnt_next;
  logic          warm_reg;
  logic          overflow_reg;

  logic [DW:0]   sum_ext;
  logic [DW-1:0] avg_scaled;
  logic          produce;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;

  // ------------------------------------------------------------------
  // Warm-up: count posedges until the first full window reaches sum_in,
  // then hold. warm is registered so it is cleanly 0 in reset even for a
  // zero-length warm-up.
  // ------------------------------------------------------------------
  always_comb begin
    warm_cnt_next = warm_cnt_reg;
    if (flush) begin
      warm_cnt_next = '0;
    end else if (warm_cnt_reg != WARM_C) begin
      warm_cnt_next = warm_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm_cnt_reg <= '0;
      warm_reg     <= 1'b0;
    end else begin
      warm_cnt_reg <= warm_cnt_next;
      warm_reg     <= (warm_cnt_next == WARM_C);
    end
  end

  assign warm = warm_reg;

  // ------------------------------------------------------------------
  // Scaler: one extra bit so the rounding term cannot wrap a near-full
  // sum (e.g. 255 + 2 with N=2 gives 64, not 0).
  // ------------------------------------------------------------------
  assign sum_ext    = {1'b0, sum_in} + RC;
  assign avg_scaled = DW'(sum_ext >> N);

  // A flush cycle never produces, even if the window was warm.
  assign produce = warm_reg & ~flush;

  // ------------------------------------------------------------------
  // Production register: the result is written into the output buffer
  // on the posedge ending the producing cycle, so it is visible on
  // avg_out one cycle after its sum_in.
  // ------------------------------------------------------------------
  assign pop = out_if.avg_valid & out_if.avg_ready;

  avg_skid_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (produce),
    .pop   (pop),
    .din   (avg_scaled),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_if.avg_out   = fifo_dout;
  assign out_if.avg_valid = ~fifo_empty;

  // Dropped result: full buffer, new result, head not leaving.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (produce && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;

endmodule

// File: tb/tb_window_avg_out_stage.sv
// ---------------------------------------------------------------------------
// tb_window_avg_out_stage
//   Directed bench. Main instance: DW=8, N=2, ADD_LAT=1, ROUND=0.
//   Second instance with ROUND=1 for the rounding vectors.
//   Inputs are driven and outputs sampled 1 time unit after each posedge.
// ---------------------------------------------------------------------------
module tb_window_avg_out_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sum_in;
  logic       flush;
  logic       warm;
  logic       overflow;
  logic [7:0] sum_r;
  logic       flush_r;
  logic       warm_r;
  logic       overflow_r;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  window_avg_out_stage_if #(.DW(8)) out_if ();
  window_avg_out_stage_if #(.DW(8)) rnd_if ();

  window_avg_out_stage #(
    .DW(8), .N(2), .ADD_LAT(1), .ROUND(0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sum_in   (sum_in),
    .flush    (flush),
    .warm     (warm),
    .overflow (overflow),
    .out_if   (out_if)
  );

  window_avg_out_stage #(
    .DW(8), .N(2), .ADD_LAT(1), .ROUND(1)
  ) dut_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .sum_in   (sum_r),
    .flush    (flush_r),
    .warm     (warm_r),
    .overflow (overflow_r),
    .out_if   (rnd_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Window sum of a counter stream (sample k enters at cycle k) seen at
  // cycle c through a 1-cycle adder: samples c-4 .. c-1.
  function automatic int win(input int c);
    int s = 0;
    for (int k = c - 4; k < c; k++) begin
      if (k >= 0) s += k;
    end
    return s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    flush_r = 1'b0;
    sum_in = 8'd0;
    sum_r = 8'd6;
    out_if.avg_ready = 1'b1;
    rnd_if.avg_ready = 1'b1;
    step();
    step();
    cmp_cnt++;
    if (out_if.avg_valid !== 1'b0 || out_if.avg_out !== 8'd0) begin
      fail_cnt++;
      $display("FAIL reset_out: valid=%b out=%0d, required valid=0 out=0", out_if.avg_valid, out_if.avg_out);
    end
    cmp_cnt++;
    if (warm !== 1'b0 || overflow !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_flags: warm=%b overflow=%b, required 0 0", warm, overflow);
    end
    $display("reset: valid=%b out=%0d warm=%b overflow=%b", out_if.avg_valid, out_if.avg_out, warm, overflow);
  endtask

  task automatic test_warmup_counter();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      sum_in = 8'(win(c));
      cmp_cnt++;
      if (warm !== (c >= 4)) begin
        fail_cnt++;
        $display("FAIL t1_warm cycle %0d: got %b, required %b", c, warm, (c >= 4));
      end
      cmp_cnt++;
      if (out_if.avg_valid !== (c >= 5)) begin
        fail_cnt++;
        $display("FAIL t1_valid cycle %0d: got %b, required %b", c, out_if.avg_valid, (c >= 5));
      end
      if (c >= 5) begin
        cmp_cnt++;
        if (out_if.avg_out !== 8'(c - 4)) begin
          fail_cnt++;
          $display("FAIL t1_avg cycle %0d: got %0d, required %0d", c, out_if.avg_out, c - 4);
        end
      end
      $display("t1 cycle %0d: sum_in=%0d warm=%b valid=%b avg=%0d", c, sum_in, warm, out_if.avg_valid, out_if.avg_out);
      step();
    end
  endtask

  task automatic test_rounding();
    int s_tab[6] = '{255, 5, 254, 253, 0, 6};
    int e_tab[6] = '{64, 1, 64, 63, 0, 2};
    sum_in = 8'd20;
    cmp_cnt++;
    if (rnd_if.avg_valid !== 1'b1 || rnd_if.avg_out !== 8'd2) begin
      fail_cnt++;
      $display("FAIL t2_round6: valid=%b avg=%0d, required valid=1 avg=2", rnd_if.avg_valid, rnd_if.avg_out);
    end
    for (int i = 0; i < 6; i++) begin
      sum_r = 8'(s_tab[i]);
      step();
      cmp_cnt++;
      if (rnd_if.avg_valid !== 1'b1 || rnd_if.avg_out !== 8'(e_tab[i])) begin
        fail_cnt++;
        $display("FAIL t2_round sum %0d: valid=%b avg=%0d, required valid=1 avg=%0d", s_tab[i], rnd_if.avg_valid, rnd_if.avg_out, e_tab[i]);
      end
      $display("t2 sum_in=%0d avg=%0d", s_tab[i], rnd_if.avg_out);
    end
  endtask

  task automatic test_stall_overflow();
    // Head is 5 (sum 20); stall for 4 pushes of 6,7,8,9.
    out_if.avg_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sum_in = 8'(4 * (6 + i));
      step();
      cmp_cnt++;
      if (out_if.avg_valid !== 1'b1 || out_if.avg_out !== 8'd5) begin
        fail_cnt++;
        $display("FAIL t3_hold stall %0d: valid=%b avg=%0d, required valid=1 avg=5", i, out_if.avg_valid, out_if.avg_out);
      end
      cmp_cnt++;
      if (overflow !== (i >= 1)) begin
        fail_cnt++;
        $display("FAIL t3_overflow stall %0d: got %b, required %b", i, overflow, (i >= 1));
      end
      $display("t3 stall %0d: avg=%0d overflow=%b", i, out_if.avg_out, overflow);
    end
    out_if.avg_ready = 1'b1;
    sum_in = 8'd44;
    step();
    cmp_cnt++;
    if (out_if.avg_out !== 8'd6) begin
      fail_cnt++;
      $display("FAIL t3_drain1: got %0d, required 6", out_if.avg_out);
    end
    sum_in = 8'd48;
    step();
    cmp_cnt++;
    if (out_if.avg_out !== 8'd11 || overflow !== 1'b1) begin
      fail_cnt++;
      $display("FAIL t3_drain2: avg=%0d overflow=%b, required 11 1", out_if.avg_out, overflow);
    end
    $display("t3 drained: avg=%0d overflow=%b", out_if.avg_out, overflow);
  endtask

  task automatic test_reset_midstream();
    rst_n = 1'b0;
    sum_in = 8'd0;
    step();
    cmp_cnt++;
    if (out_if.avg_valid !== 1'b0 || out_if.avg_out !== 8'd0 || overflow !== 1'b0 || warm !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t6_reset: valid=%b avg=%0d overflow=%b warm=%b, required all 0", out_if.avg_valid, out_if.avg_out, overflow, warm);
    end
    $display("t6 reset: valid=%b avg=%0d overflow=%b warm=%b", out_if.avg_valid, out_if.avg_out, overflow, warm);
  endtask

  task automatic test_full_pop_push();
    int exp_tab[4] = '{10, 11, 12, 13};
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cmp_cnt++;
      if (warm !== (c == 4) || out_if.avg_valid !== 1'b0) begin
        fail_cnt++;
        $display("FAIL t4_rewarm cycle %0d: warm=%b valid=%b, required %b 0", c, warm, out_if.avg_valid, (c == 4));
      end
      if (c == 4) sum_in = 8'd40;
      step();
    end
    // Head 10; one stalled push fills the buffer.
    out_if.avg_ready = 1'b0;
    sum_in = 8'd44;
    step();
    out_if.avg_ready = 1'b1;
    // Full buffer, pop and push each cycle.
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (out_if.avg_out !== 8'(exp_tab[i]) || overflow !== 1'b0) begin
        fail_cnt++;
        $display("FAIL t4_order %0d: avg=%0d overflow=%b, required %0d 0", i, out_if.avg_out, overflow, exp_tab[i]);
      end
      $display("t4 step %0d: avg=%0d overflow=%b", i, out_if.avg_out, overflow);
      sum_in = 8'(48 + 4 * i);
      step();
    end
    // Buffer now [14,15]; a stalled push must be dropped.
    out_if.avg_ready = 1'b0;
    sum_in = 8'd60;
    step();
    cmp_cnt++;
    if (overflow !== 1'b1 || out_if.avg_out !== 8'd14) begin
      fail_cnt++;
      $display("FAIL t4_still_full: overflow=%b avg=%0d, required 1 14", overflow, out_if.avg_out);
    end
  endtask

  task automatic test_flush();
    int      exp_avg;
    logic    exp_valid;
    flush = 1'b1;
    sum_in = 8'd64;
    step();
    flush = 1'b0;
    out_if.avg_ready = 1'b1;
    sum_in = 8'd80;
    for (int k = 1; k <= 6; k++) begin
      exp_valid = (k <= 2) || (k == 6);
      exp_avg   = (k == 1) ? 14 : (k == 2) ? 15 : (k == 6) ? 20 : 0;
      cmp_cnt++;
      if (warm !== (k >= 5)) begin
        fail_cnt++;
        $display("FAIL t5_warm k=%0d: got %b, required %b", k, warm, (k >= 5));
      end
      cmp_cnt++;
      if (out_if.avg_valid !== exp_valid || out_if.avg_out !== 8'(exp_avg)) begin
        fail_cnt++;
        $display("FAIL t5_out k=%0d: valid=%b avg=%0d, required %b %0d", k, out_if.avg_valid, out_if.avg_out, exp_valid, exp_avg);
      end
      $display("t5 k=%0d: warm=%b valid=%b avg=%0d", k, warm, out_if.avg_valid, out_if.avg_out);
      if (k < 6) step();
    end
    cmp_cnt++;
    if (overflow !== 1'b1) begin
      fail_cnt++;
      $display("FAIL t5_sticky: overflow=%b, required 1", overflow);
    end
  endtask

  initial begin
    test_reset();
    test_warmup_counter();
    test_rounding();
    test_stall_overflow();
    test_reset_midstream();
    test_full_pop_push();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
